// File: rtl/float_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : float_sub_seq
// Purpose  : Iterative IEEE-754 single-precision subtractor, vres = v1 - v2.
//            Unpack -> align -> add/sub -> shift-loop normalise -> RNE round.
//            Denormal inputs flush to zero; results too small flush to zero.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            start  one-cycle request, v1/v2 sampled while idle
//            v1,v2  minuend / subtrahend
//            busy   operation in flight
//            done   one-cycle pulse, vres/flags valid
//            vres   result, held until the next accepted start
//            flags  {invalid, overflow, underflow, inexact}
// Revision : 1.0 - initial release
// ============================================================================
module float_sub_seq #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int MAX_NORM = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [EXP_W+MAN_W:0] v1,
    input  logic [EXP_W+MAN_W:0] v2,
    output logic               busy,
    output logic               done,
    output logic [EXP_W+MAN_W:0] vres,
    output logic [3:0]         flags
);

    localparam int c_w     = 1 + EXP_W + MAN_W;   // word width
    localparam int c_m     = MAN_W + 4;           // hidden + fraction + G/R/S
    localparam int c_sh_w  = $clog2(c_m + 1);
    localparam int c_cnt_w = $clog2(MAX_NORM + 1);
    localparam logic [EXP_W:0]   c_emax = {1'b0, {EXP_W{1'b1}}};
    localparam logic [c_w-1:0]   c_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t               r_state, w_next;
    logic [c_w-1:0]       r_op1, r_op2;       // r_op2 carries the inverted sign
    logic [EXP_W-1:0]     r_ea, r_eb;
    logic [c_m-1:0]       r_ma, r_mb;
    logic [EXP_W:0]       r_e;                // extra bit catches exponent overflow
    logic [c_m:0]         r_m;                // bit c_m is the adder carry-out
    logic                 r_sign, r_sub;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_w-1:0]       r_vres;
    logic [3:0]           r_flags;

    // ------------------------------------------------------------------ unpack
    logic [EXP_W-1:0] w_e1, w_e2;
    logic [MAN_W-1:0] w_f1, w_f2;
    logic             w_s1, w_s2;
    logic             w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2, w_special;
    logic [c_w-1:0]   w_spec_res;
    logic [3:0]       w_spec_flg;

    assign w_s1 = r_op1[c_w-1];
    assign w_s2 = r_op2[c_w-1];
    assign w_e1 = r_op1[c_w-2:MAN_W];
    assign w_e2 = r_op2[c_w-2:MAN_W];
    assign w_f1 = r_op1[MAN_W-1:0];
    assign w_f2 = r_op2[MAN_W-1:0];

    assign w_nan1  = (&w_e1) &  (|w_f1);
    assign w_nan2  = (&w_e2) &  (|w_f2);
    assign w_inf1  = (&w_e1) & ~(|w_f1);
    assign w_inf2  = (&w_e2) & ~(|w_f2);
    // exponent 0 covers both true zero and denormals, which are flushed
    assign w_zero1 = ~(|w_e1);
    assign w_zero2 = ~(|w_e2);
    assign w_special = w_nan1 | w_nan2 | w_inf1 | w_inf2 | (w_zero1 & w_zero2);

    always_comb begin
        w_spec_res = '0;
        w_spec_flg = 4'b0000;
        if (w_nan1 | w_nan2 | (w_inf1 & w_inf2 & (w_s1 ^ w_s2))) begin
            w_spec_res = c_qnan;
            w_spec_flg = 4'b1000;
        end else if (w_inf1) begin
            w_spec_res = {w_s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_inf2) begin
            w_spec_res = {w_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            // both zero: negative only for (-0) - (+0)
            w_spec_res = {w_s1 & w_s2, {(c_w-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------- align
    logic             w_a_ge;
    logic [EXP_W-1:0] w_big_e, w_sml_e, w_diff;
    logic [c_m-1:0]   w_big_m, w_sml_m, w_mask, w_aligned;
    logic [c_sh_w-1:0] w_sh;
    logic             w_lost;

    assign w_a_ge  = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_big_e = w_a_ge ? r_ea : r_eb;
    assign w_sml_e = w_a_ge ? r_eb : r_ea;
    assign w_big_m = w_a_ge ? r_ma : r_mb;
    assign w_sml_m = w_a_ge ? r_mb : r_ma;
    assign w_diff  = w_big_e - w_sml_e;
    assign w_sh    = (w_diff > EXP_W'(c_m)) ? c_sh_w'(c_m) : w_diff[c_sh_w-1:0];
    assign w_mask  = ~({c_m{1'b1}} << w_sh);
    assign w_lost  = |(w_sml_m & w_mask);
    assign w_aligned = (w_sml_m >> w_sh) | {{(c_m-1){1'b0}}, w_lost};

    // ------------------------------------------------------------------ addsub
    logic [c_m:0] w_sum;
    assign w_sum = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb})
                         : ({1'b0, r_ma} + {1'b0, r_mb});

    // -------------------------------------------------------------------- norm
    logic               w_carry, w_uflow, w_norm_done;
    logic [EXP_W:0]     w_e_dec;
    logic [c_cnt_w-1:0] w_cnt_nx;

    assign w_carry     = r_m[c_m];
    assign w_e_dec     = r_e - 1'b1;
    assign w_cnt_nx    = r_cnt + 1'b1;
    assign w_uflow     = ~w_carry & (w_e_dec == '0);
    // look one bit ahead so the shift that sets the MSB also leaves the loop
    assign w_norm_done = w_carry | r_m[c_m-2] | (w_cnt_nx >= c_cnt_w'(MAX_NORM));

    // ------------------------------------------------------------------- round
    logic               w_g, w_r, w_st, w_up, w_inex, w_rcarry, w_ovf;
    logic [MAN_W+1:0]   w_rnd;
    logic [EXP_W:0]     w_e_fin;
    logic [MAN_W-1:0]   w_frac;

    assign w_g      = r_m[2];
    assign w_r      = r_m[1];
    assign w_st     = r_m[0];
    assign w_inex   = w_g | w_r | w_st;
    assign w_up     = w_g & (w_r | w_st | r_m[3]);
    assign w_rnd    = {1'b0, r_m[c_m-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_rcarry = w_rnd[MAN_W+1];
    assign w_e_fin  = r_e + {{EXP_W{1'b0}}, w_rcarry};
    assign w_ovf    = w_e_fin >= c_emax;
    assign w_frac   = w_rcarry ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

    // --------------------------------------------------------------------- fsm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_UNPACK;
            S_UNPACK: w_next = w_special ? S_DONE : S_ALIGN;
            S_ALIGN:  w_next = S_ADDSUB;
            S_ADDSUB: begin
                if (w_sum == '0)                         w_next = S_DONE;
                else if (w_sum[c_m] | ~w_sum[c_m-1])     w_next = S_NORM;
                else                                     w_next = S_ROUND;
            end
            S_NORM: begin
                if (w_uflow)          w_next = S_DONE;
                else if (w_norm_done) w_next = S_ROUND;
                else                  w_next = S_NORM;
            end
            S_ROUND:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_ea    <= '0;
            r_eb    <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_e     <= '0;
            r_m     <= '0;
            r_sign  <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            r_vres  <= '0;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op1 <= v1;
                        r_op2 <= {~v2[c_w-1], v2[c_w-2:0]};
                        r_cnt <= '0;
                    end
                end
                S_UNPACK: begin
                    if (w_special) begin
                        r_vres  <= w_spec_res;
                        r_flags <= w_spec_flg;
                    end
                    r_ea <= w_zero1 ? '0 : w_e1;
                    r_eb <= w_zero2 ? '0 : w_e2;
                    r_ma <= w_zero1 ? '0 : {1'b1, w_f1, 3'b000};
                    r_mb <= w_zero2 ? '0 : {1'b1, w_f2, 3'b000};
                end
                S_ALIGN: begin
                    r_e    <= {1'b0, w_big_e};
                    r_ma   <= w_big_m;
                    r_mb   <= w_aligned;
                    r_sign <= w_a_ge ? w_s1 : w_s2;
                    r_sub  <= w_s1 ^ w_s2;
                end
                S_ADDSUB: begin
                    r_m <= w_sum;
                    if (w_sum == '0) begin
                        r_vres  <= '0;
                        r_flags <= 4'b0000;
                    end
                end
                S_NORM: begin
                    if (w_carry) begin
                        // fold the dropped bit into sticky
                        r_m <= {1'b0, r_m[c_m:2], r_m[1] | r_m[0]};
                        r_e <= r_e + 1'b1;
                    end else if (w_uflow) begin
                        r_vres  <= {r_sign, {(c_w-1){1'b0}}};
                        r_flags <= 4'b0010;
                    end else begin
                        r_m   <= {r_m[c_m-1:0], 1'b0};
                        r_e   <= w_e_dec;
                        r_cnt <= w_cnt_nx;
                    end
                end
                S_ROUND: begin
                    if (w_ovf) begin
                        r_vres  <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_flags <= 4'b0101;
                    end else begin
                        r_vres  <= {r_sign, w_e_fin[EXP_W-1:0], w_frac};
                        r_flags <= {3'b000, w_inex};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done  = (r_state == S_DONE);
    assign vres  = r_vres;
    assign flags = r_flags;

endmodule
`default_nettype wire
